// File: rtl/telemetria_tx_pkg.sv
// Shared constants, state encodings and packet byte builder for the
// telemetry UART transmitter.
package telemetria_tx_pkg;

  localparam logic [7:0] CABECALHO       = 8'hA5;
  localparam int         N_BYTES_SEM_CHK = 3;
  localparam int         N_BYTES_COM_CHK = 4;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    INICIO  = 3'd1,
    DADOS   = 3'd2,
    PARADA  = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  typedef enum logic [1:0] {
    FASE_LIVRE  = 2'd0,
    FASE_INICIO = 2'd1,
    FASE_DADOS  = 2'd2,
    FASE_PARADA = 2'd3
  } fase_t;

  typedef struct packed {
    logic [9:0] pontuacao;
    logic [1:0] nivel;
    logic       ganhou;
    logic       perdeu;
  } snapshot_t;

  // Byte idx of the packet built from the captured snapshot; idx 3 is the checksum.
  function automatic logic [7:0] byte_pacote(input snapshot_t s, input logic [1:0] idx);
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] res;
    b1 = {s.nivel, s.ganhou, s.perdeu, 2'b00, s.pontuacao[9:8]};
    b2 = s.pontuacao[7:0];
    case (idx)
      2'd0:    res = CABECALHO;
      2'd1:    res = b1;
      2'd2:    res = b2;
      default: res = CABECALHO ^ b1 ^ b2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Bit-level 8N1 serializer: one start bit, eight data bits LSB first, one stop
// bit, each held t_bit cycles. A start on the last stop cycle chains bytes with no gap.
module uart_tx_byte
  import telemetria_tx_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int TW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    dado,
  input  logic [TW-1:0] t_bit,
  output logic          serial,
  output logic          fim_bit,
  output logic          fim_byte
);

  fase_t            fase;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sreg;
  logic [TW-1:0]    t_ult;

  assign t_ult    = t_bit - 1'b1;
  assign fim_bit  = (fase != FASE_LIVRE) && (TW'(cnt) == t_ult);
  assign fim_byte = (fase == FASE_PARADA) && fim_bit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fase    <= FASE_LIVRE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      sreg    <= 8'd0;
      serial  <= 1'b1;
    end else if (start && (fase == FASE_LIVRE || fim_byte)) begin
      fase    <= FASE_INICIO;
      cnt     <= '0;
      bit_idx <= 3'd0;
      sreg    <= dado;
      serial  <= 1'b0;
    end else begin
      case (fase)
        FASE_INICIO: begin
          if (fim_bit) begin
            fase   <= FASE_DADOS;
            cnt    <= '0;
            serial <= sreg[0];
            sreg   <= {1'b0, sreg[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FASE_DADOS: begin
          if (fim_bit) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              fase   <= FASE_PARADA;
              serial <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              serial  <= sreg[0];
              sreg    <= {1'b0, sreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FASE_PARADA: begin
          if (fim_bit) begin
            fase <= FASE_LIVRE;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          serial <= 1'b1;
        end
        default: begin
          cnt    <= '0;
          serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/telemetria_tx.sv
// Telemetry packet transmitter: snapshots score/level/flags on enviar and sends
// A5, B1, B2 (and the XOR checksum when TELEMETRIA_CHECKSUM_EN is defined) over 8N1 UART.
//
// state   | meaning
// OCIOSO  | idle, line high, waiting for enviar
// INICIO  | start bit of the current byte
// DADOS   | eight data bits, LSB first
// PARADA  | stop bit; at its end PROXIMO decides next byte or FIM
// PROXIMO | zero-duration decision, never held
// FIM     | one cycle: pronto pulses, ocupado already low
module telemetria_tx
  import telemetria_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [9:0] pontuacao,
  input  logic [1:0] nivel_dificuldade,
  input  logic       ganhou_ponto,
  input  logic       perdeu_ponto,
  output logic       serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int T     = CLK_FREQ / BAUD;
  localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
  localparam int TW    = $clog2(T + 1);
`ifdef TELEMETRIA_CHECKSUM_EN
  localparam int N_BYTES = N_BYTES_COM_CHK;
`else
  localparam int N_BYTES = N_BYTES_SEM_CHK;
`endif
  localparam logic [TW-1:0] T_BIT      = TW'(T);
  localparam logic [1:0]    ULTIMO_IDX = 2'(N_BYTES - 1);

  estado_t   estado;
  snapshot_t snap;
  logic [1:0] byte_idx;
  logic [1:0] idx_sel;
  logic [2:0] bit_cnt;
  logic [7:0] dado;
  logic       aceita;
  logic       ultimo;
  logic       start;
  logic       fim_bit;
  logic       fim_byte;

  // Start is combinational so the next start bit appears the cycle after acceptance
  // or immediately after the previous stop bit.
  assign aceita    = (estado == OCIOSO) && enviar;
  assign ultimo    = (byte_idx == ULTIMO_IDX);
  assign start     = aceita || (fim_byte && !ultimo);
  assign idx_sel   = aceita ? 2'd0 : byte_idx + 2'd1;
  assign dado      = byte_pacote(snap, idx_sel);
  assign db_estado = {1'b0, estado};

  uart_tx_byte #(
    .CNT_W (CNT_W),
    .TW    (TW)
  ) u_byte (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dado     (dado),
    .t_bit    (T_BIT),
    .serial   (serial),
    .fim_bit  (fim_bit),
    .fim_byte (fim_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      snap     <= '0;
      byte_idx <= 2'd0;
      bit_cnt  <= 3'd0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            estado   <= INICIO;
            ocupado  <= 1'b1;
            byte_idx <= 2'd0;
            bit_cnt  <= 3'd0;
            snap     <= {pontuacao, nivel_dificuldade, ganhou_ponto, perdeu_ponto};
          end
        end
        INICIO: begin
          if (fim_bit) begin
            estado  <= DADOS;
            bit_cnt <= 3'd0;
          end
        end
        DADOS: begin
          if (fim_bit) begin
            if (bit_cnt == 3'd7) estado <= PARADA;
            else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARADA: begin
          // The PROXIMO decision is folded into the last stop-bit cycle.
          if (fim_bit) begin
            if (!ultimo) begin
              estado   <= INICIO;
              byte_idx <= byte_idx + 2'd1;
            end else begin
              estado  <= FIM;
              ocupado <= 1'b0;
              pronto  <= 1'b1;
            end
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_telemetria_tx.sv
// Directed bench for telemetria_tx: packet contents, timing, ignored requests,
// snapshot isolation, mid-packet reset and default bit width.
module tb_telemetria_tx;

  localparam int T = 10;
`ifdef TELEMETRIA_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clock;
  logic       reset;
  logic       enviar;
  logic [9:0] pontuacao;
  logic [1:0] nivel;
  logic       ganhou;
  logic       perdeu;
  logic       serial;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic       enviar_r;
  logic       serial_r;
  logic       ocupado_r;
  logic       pronto_r;
  logic [3:0] db_estado_r;

  int checks = 0;
  int errors = 0;

  telemetria_tx #(.CLK_FREQ(10), .BAUD(1)) dut (
    .clock             (clock),
    .reset             (reset),
    .enviar            (enviar),
    .pontuacao         (pontuacao),
    .nivel_dificuldade (nivel),
    .ganhou_ponto      (ganhou),
    .perdeu_ponto      (perdeu),
    .serial            (serial),
    .ocupado           (ocupado),
    .pronto            (pronto),
    .db_estado         (db_estado)
  );

  telemetria_tx dut_r (
    .clock             (clock),
    .reset             (reset),
    .enviar            (enviar_r),
    .pontuacao         (10'h2C7),
    .nivel_dificuldade (2'b10),
    .ganhou_ponto      (1'b1),
    .perdeu_ponto      (1'b0),
    .serial            (serial_r),
    .ocupado           (ocupado_r),
    .pronto            (pronto_r),
    .db_estado         (db_estado_r)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_packet(input logic [9:0] p, input logic [1:0] nv, input logic g,
                            input logic d, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input bit perturbar);
    logic [7:0] esp [4];
    logic [7:0] capt [4];
    int bit_err;
    int ctl_err;
    int idle_err;
    int bi;
    int bp;
    int ph;
    logic eb;
    esp[0] = 8'hA5; esp[1] = e1; esp[2] = e2; esp[3] = e3;
    for (int i = 0; i < 4; i++) capt[i] = 8'h00;
    bit_err = 0; ctl_err = 0; idle_err = 0;
    @(negedge clock);
    pontuacao = p; nivel = nv; ganhou = g; perdeu = d; enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
    chk("start_serial", serial, 1'b0);
    chk("start_ocupado", ocupado, 1'b1);
    chk("start_estado", db_estado, 4'd1);
    if (perturbar) begin
      pontuacao = 10'd0; nivel = 2'd0; ganhou = 1'b0; perdeu = 1'b0;
    end
    for (int k = 0; k < NB * 10 * T; k++) begin
      if (k > 0) @(negedge clock);
      bi = k / (10 * T);
      bp = (k % (10 * T)) / T;
      ph = k % T;
      if (bp == 0) eb = 1'b0;
      else if (bp == 9) eb = 1'b1;
      else eb = esp[bi][bp-1];
      if (serial !== eb) bit_err++;
      if (ph == T / 2 && bp >= 1 && bp <= 8) capt[bi][bp-1] = serial;
      if (ocupado !== 1'b1 || pronto !== 1'b0) ctl_err++;
      if (perturbar && k == 49) enviar = 1'b1;
      if (perturbar && k == 50) enviar = 1'b0;
    end
    for (int i = 0; i < NB; i++) chk($sformatf("byte%0d", i), capt[i], esp[i]);
    chk("bit_cycles_wrong", bit_err, 0);
    chk("busy_window_wrong", ctl_err, 0);
    @(negedge clock);
    chk("pronto_pulse", pronto, 1'b1);
    chk("pronto_ocupado", ocupado, 1'b0);
    chk("pronto_serial", serial, 1'b1);
    chk("pronto_estado", db_estado, 4'd5);
    if (perturbar) enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
    chk("after_pronto", pronto, 1'b0);
    chk("after_estado", db_estado, 4'd0);
    for (int i = 0; i < 3 * T; i++) begin
      @(negedge clock);
      if (ocupado !== 1'b0 || serial !== 1'b1 || pronto !== 1'b0) idle_err++;
    end
    chk("idle_after_packet", idle_err, 0);
  endtask

  initial begin
    int bad;
    int largura;
    reset = 1'b0; enviar = 1'b0; enviar_r = 1'b0;
    pontuacao = 10'd0; nivel = 2'd0; ganhou = 1'b0; perdeu = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_serial", serial, 1'b1);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_pronto", pronto, 1'b0);
    chk("rst_estado", db_estado, 4'd0);
    reset = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (serial !== 1'b1 || ocupado !== 1'b0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    run_packet(10'h2C7, 2'b10, 1'b1, 1'b0, 8'hA2, 8'hC7, 8'hC0, 1'b0);
    run_packet(10'h2C7, 2'b10, 1'b1, 1'b0, 8'hA2, 8'hC7, 8'hC0, 1'b1);

    @(negedge clock);
    pontuacao = 10'h2C7; nivel = 2'b10; ganhou = 1'b1; perdeu = 1'b0; enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
    repeat (149) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_serial", serial, 1'b1);
    chk("midrst_ocupado", ocupado, 1'b0);
    chk("midrst_estado", db_estado, 4'd0);
    chk("midrst_pronto", pronto, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (NB * 10 * T) begin
      @(negedge clock);
      if (pronto !== 1'b0 || serial !== 1'b1 || ocupado !== 1'b0) bad++;
    end
    chk("quiet_after_midrst", bad, 0);

    run_packet(10'h155, 2'b01, 1'b0, 1'b1, 8'h51, 8'h55, 8'hA1, 1'b0);

    @(negedge clock);
    enviar_r = 1'b1;
    @(negedge clock);
    enviar_r = 1'b0;
    chk("fast_start", serial_r, 1'b0);
    largura = 0;
    while (serial_r === 1'b0 && largura < 2000) begin
      largura++;
      @(negedge clock);
    end
    chk("fast_bit_width", largura, 434);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/telemetria_tx.md
TELEMETRIA_TX -- requirements
Module: telemetria_tx

Interface
REQ-001 The block SHALL have a parameter CLK_FREQ, default 50000000, giving the clock frequency in Hz.
REQ-002 The block SHALL have a parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 The block SHALL have the port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port enviar, input, 1 bit: send request, one cycle wide.
REQ-006 The block SHALL have the port pontuacao, input, 10 bits: current score.
REQ-007 The block SHALL have the port nivel_dificuldade, input, 2 bits: current level.
REQ-008 The block SHALL have the port ganhou_ponto, input, 1 bit: point-won flag.
REQ-009 The block SHALL have the port perdeu_ponto, input, 1 bit: point-lost flag.
REQ-010 The block SHALL have the port serial, output, 1 bit: UART line, 8N1, LSB first, idle high.
REQ-011 The block SHALL have the port ocupado, output, 1 bit: packet in progress.
REQ-012 The block SHALL have the port pronto, output, 1 bit: one-cycle pulse when a packet completes.
REQ-013 The block SHALL have the port db_estado, output, 4 bits: encoding of the current FSM state.

Function
REQ-014 Bit period SHALL be T = CLK_FREQ/BAUD clock cycles (integer division, truncated); a counter of width clog2(T) counts 0..T-1.
REQ-015 enviar SHALL be accepted only when ocupado=0; in the acceptance cycle, pontuacao, nivel_dificuldade, ganhou_ponto and perdeu_ponto SHALL be captured into a snapshot register.
REQ-016 The packet SHALL use the snapshot only; input changes after acceptance do not affect it.
REQ-017 Byte order SHALL be B0=0xA5 (header), B1={nivel[1:0], ganhou, perdeu, 2'b00, pontuacao[9:8]}, B2=pontuacao[7:0], then B3=B0^B1^B2 (checksum, see Configuration).
REQ-018 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each held for T cycles; bytes SHALL be sent back-to-back with no idle gap.
REQ-019 ocupado and serial=0 (start bit of B0) SHALL both assert in the cycle after acceptance.
REQ-020 Once the last stop bit has been held T cycles, the block SHALL, in the next cycle, pulse pronto for one cycle, clear ocupado, and return serial to idle.
REQ-021 enviar while ocupado=1, including the cycle pronto is high, SHALL be ignored; there is no queue.
REQ-022 The FSM SHALL have the states OCIOSO=0, INICIO=1, DADOS=2, PARADA=3, PROXIMO=4, FIM=5, with transitions:
- OCIOSO->INICIO on accepted enviar
- INICIO->DADOS after T cycles
- DADOS->PARADA after 8 bits
- PARADA->PROXIMO after T cycles
- PROXIMO->INICIO if bytes remain, else ->FIM; PROXIMO is a zero-duration decision, taken in the same cycle and not held
- FIM->OCIOSO after one cycle
REQ-023 db_estado SHALL present the state encoding zero-extended to 4 bits.

Reset
REQ-024 reset=0 SHALL immediately force OCIOSO, serial=1, ocupado=0, pronto=0, db_estado=0, and clear all counters and the snapshot, including in the middle of a byte.
REQ-025 After reset deasserts, serial SHALL stay high until the next accepted enviar.

Configuration
REQ-026 With TELEMETRIA_CHECKSUM_EN defined, the packet SHALL be 4 bytes (B0..B3).
REQ-027 Without TELEMETRIA_CHECKSUM_EN, the packet SHALL be 3 bytes (B0..B2), and pronto SHALL follow B2's stop bit.

Structure
REQ-028 The shared package SHALL hold the header constant 0xA5, the FSM state encodings, and the packet-length constants (3 and 4).
REQ-029 The bit-level serializer SHALL be one sub-module, uart_tx_byte, which takes a byte, start and T, and returns serial and fim_byte; telemetria_tx sequences the bytes.

Verification
REQ-030 CLK_FREQ=10, BAUD=1, checksum enabled; enviar with pontuacao=0x2C7, nivel=2'b10, ganhou=1, perdeu=0 -> serial carries A5, A2, C7, C0, each bit 10 cycles; pronto fires 401 cycles after enviar.
REQ-031 Same parameters, checksum disabled -> bytes A5, A2, C7 only; pronto 301 cycles after enviar.
REQ-032 enviar pulsed again 50 cycles into a packet, and again in the pronto cycle -> both ignored; exactly one packet is sent.
REQ-033 Inputs changed to pontuacao=0, nivel=0 one cycle after acceptance -> B1 and B2 still A2 and C7.
REQ-034 reset=0 at cycle 150 of a packet -> serial=1, ocupado=0, db_estado=0 immediately; no pronto; a new enviar after release sends a full packet.
REQ-035 CLK_FREQ=50000000, BAUD=115200 -> every bit is 434 cycles wide (checked at the start-bit edge).
